// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed N-digit 7-segment display.
// Double-buffered display data, per-slot blanking, optional leading-zero suppression.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int BLANK      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start,
  output logic                    upd_pending
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  typedef enum logic {
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [4*NUM_DIGITS-1:0] active;

  logic                    slot_end;
  logic                    frame_end;
  logic                    hi_zero;
  logic [3:0]              show_code;
  logic [NUM_DIGITS-1:0]   show_en;

  // Code and enable for the current digit; a digit is suppressed when it and
  // everything above it is zero, except digit 0 which always shows.
  always_comb begin
    slot_end  = (state == S_SHOW) && (cnt == CW'(DWELL - 1));
    frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));
    hi_zero   = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= int'(idx)) && (active[4*k +: 4] != 4'h0)) begin
        hi_zero = 1'b0;
      end
    end
    show_code = active[{idx, 2'b00} +: 4];
    if (lz_en && (idx != '0) && hi_zero) begin
      show_code = 4'hF;
    end
    show_en = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BLANK;
      cnt         <= '0;
      idx         <= '0;
      shadow      <= '0;
      active      <= '0;
      bcd_out     <= 4'hF;
      digit_en    <= '0;
      frame_start <= 1'b0;
      upd_pending <= 1'b0;
    end else begin
      frame_start <= frame_end;
      // The boundary copies the pre-load shadow, so a coincident load waits a frame.
      if (frame_end) begin
        active <= shadow;
      end
      if (load) begin
        shadow      <= data;
        upd_pending <= 1'b1;
      end else if (frame_end) begin
        upd_pending <= 1'b0;
      end

      case (state)
        S_BLANK: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BLANK - 1)) begin
            state    <= S_SHOW;
            bcd_out  <= show_code;
            digit_en <= show_en;
          end
        end
        S_SHOW: begin
          if (slot_end) begin
            state    <= S_BLANK;
            cnt      <= '0;
            idx      <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            bcd_out  <= 4'hF;
            digit_en <= '0;
          end else begin
            cnt      <= cnt + 1'b1;
            bcd_out  <= show_code;
            digit_en <= show_en;
          end
        end
        default: begin
          state    <= S_BLANK;
          cnt      <= '0;
          bcd_out  <= 4'hF;
          digit_en <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed and random loads checked each
// cycle against a reference computed from cycle arithmetic since reset release.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DW    = 6;
  localparam int BL    = 2;
  localparam int FRAME = N * DW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic        lz_en = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_en;
  logic        frame_start;
  logic        upd_pending;

  int total = 0;
  int bad = 0;

  // reference: cycle number since release, buffered values, pending flag
  int          t;
  logic [15:0] m_shadow;
  logic [15:0] m_active;
  logic        m_upd;
  logic        lz_prev;

  seg_scan_ctrl #(.NUM_DIGITS(N), .DWELL(DW), .BLANK(BL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data       (data),
    .lz_en      (lz_en),
    .bcd_out    (bcd_out),
    .digit_en   (digit_en),
    .frame_start(frame_start),
    .upd_pending(upd_pending)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0d got=%h want=%h", tag, t, got, exp);
    end
  endtask

  task automatic resetModel();
    t        = 0;
    m_shadow = 16'h0;
    m_active = 16'h0;
    m_upd    = 1'b0;
    lz_prev  = 1'b0;
  endtask

  // Expected outputs for cycle t: slot position and digit come from t alone.
  task automatic checkCycle();
    int          pos;
    int          dig;
    logic [15:0] upper;
    logic [3:0]  e_bcd;
    logic [3:0]  e_en;
    pos = t % DW;
    dig = (t / DW) % N;
    if (pos < BL) begin
      e_bcd = 4'hF;
      e_en  = 4'h0;
    end else begin
      upper = m_active >> (4 * dig);
      e_bcd = upper[3:0];
      if (lz_prev && dig != 0 && upper == 16'h0) e_bcd = 4'hF;
      e_en = 4'(1 << dig);
    end
    checkOutput("bcd_out", 32'(bcd_out), 32'(e_bcd));
    checkOutput("digit_en", 32'(digit_en), 32'(e_en));
    checkOutput("frame_start", 32'(frame_start), 32'((t > 0) && (t % FRAME == 0)));
    checkOutput("upd_pending", 32'(upd_pending), 32'(m_upd));
  endtask

  // Check the current cycle, drive inputs for the next edge, advance the model.
  task automatic applyStimulus(input logic ld, input logic [15:0] d, input logic lz);
    checkCycle();
    load  = ld;
    data  = d;
    lz_en = lz;
    if ((t + 1) % FRAME == 0) begin
      m_active = m_shadow;
      if (!ld) m_upd = 1'b0;
    end
    if (ld) begin
      m_shadow = d;
      m_upd    = 1'b1;
    end
    lz_prev = lz;
    @(negedge clk);
    t++;
  endtask

  task automatic runIdle(input int n, input logic lz);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, data, lz);
  endtask

  task automatic loadAndRun(input logic [15:0] d, input logic lz, input int frames);
    applyStimulus(1'b1, d, lz);
    runIdle(frames * FRAME, lz);
  endtask

  function automatic logic [15:0] pickData();
    logic [15:0] table_v [4];
    int          sel;
    table_v[0] = 16'h1234;
    table_v[1] = 16'h0050;
    table_v[2] = 16'h0000;
    table_v[3] = 16'hA9F0;
    sel = int'($urandom_range(0, 5));
    if (sel < 4) return table_v[sel];
    return 16'($urandom());
  endfunction

  initial begin
    resetModel();
    repeat (3) @(negedge clk);
    checkOutput("rst_bcd", 32'(bcd_out), 32'hF);
    checkOutput("rst_en", 32'(digit_en), 32'h0);
    checkOutput("rst_fs", 32'(frame_start), 32'h0);
    checkOutput("rst_upd", 32'(upd_pending), 32'h0);
    rst_n = 1'b1;

    // basic scan of 0x1234, then double-buffered update mid-frame
    loadAndRun(16'h1234, 1'b0, 2);
    loadAndRun(16'h1111, 1'b0, 2);
    runIdle(2 * DW + 3, 1'b0);
    loadAndRun(16'h2222, 1'b0, 2);

    // load exactly on a boundary edge, then a second load the next frame
    while ((t + 1) % FRAME != 0) applyStimulus(1'b0, data, 1'b0);
    applyStimulus(1'b1, 16'h5678, 1'b0);
    runIdle(FRAME, 1'b0);
    while ((t + 1) % FRAME != 0) applyStimulus(1'b0, data, 1'b0);
    applyStimulus(1'b1, 16'h9012, 1'b0);
    runIdle(2 * FRAME, 1'b0);

    // leading-zero suppression and invalid codes
    loadAndRun(16'h0050, 1'b1, 2);
    loadAndRun(16'h0000, 1'b1, 2);
    runIdle(FRAME, 1'b0);
    loadAndRun(16'hA9F0, 1'b0, 2);
    loadAndRun(16'h0700, 1'b1, 2);

    // random loads, random lz_en, loads favoured at frame boundaries
    for (int i = 0; i < 1500; i++) begin
      logic ld;
      logic lz;
      if ((t + 1) % FRAME == 0) ld = ($urandom_range(0, 1) == 1);
      else                      ld = ($urandom_range(0, 9) == 0);
      lz = ($urandom_range(0, 9) == 0) ? ~lz_en : lz_en;
      applyStimulus(ld, ld ? pickData() : data, lz);
    end

    // async reset while digit 2 is shown
    loadAndRun(16'h4321, 1'b0, 1);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((t / DW) % N == 2 && (t % DW) >= BL + 1) break;
      applyStimulus(1'b0, data, 1'b0);
    end
    checkOutput("pre_rst_en", 32'(digit_en), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_bcd", 32'(bcd_out), 32'hF);
    checkOutput("async_en", 32'(digit_en), 32'h0);
    checkOutput("async_fs", 32'(frame_start), 32'h0);
    checkOutput("async_upd", 32'(upd_pending), 32'h0);
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    runIdle(2 * FRAME, 1'b0);
    loadAndRun(16'h0908, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
